// File: rtl/bitty_sequencer.sv
// bitty_sequencer: fetch/issue/retire controller for the bitty core.
// Owns the PC, paces memory and core, adds step/breakpoint/watchdog.
module bitty_sequencer #(
  parameter int AW = 8,
  parameter int CW = 16,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 64,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          mode_step,
  input  logic          step,
  input  logic          clear,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] new_pc,
  input  logic          core_done,
  output logic [AW-1:0] pc,
  output logic          mem_rd,
  output logic          core_run,
  output logic          halted,
  output logic          wd_err,
  output logic [CW-1:0] instr_count,
  output logic [2:0]    state
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LAT_END = LW'(MEM_LAT - 1);
  localparam logic [WW-1:0] WD_END = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    EXEC   = 3'd3,
    UPDATE = 3'd4,
    HALT   = 3'd5
  } fsm_t;

  fsm_t          fsm;
  logic [LW-1:0] lat;
  logic [WW-1:0] wd;
  logic [AW-1:0] npc;

  assign state  = fsm;
  assign halted = (fsm == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      pc          <= RESET_PC;
      npc         <= RESET_PC;
      lat         <= '0;
      wd          <= '0;
      mem_rd      <= 1'b0;
      core_run    <= 1'b0;
      wd_err      <= 1'b0;
      instr_count <= '0;
    end else begin
      mem_rd   <= 1'b0;
      core_run <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (run && (!mode_step || step)) begin
            fsm    <= FETCH;
            mem_rd <= 1'b1;
            lat    <= '0;
          end
        end
        FETCH: begin
          if (lat == LAT_END) begin
            fsm      <= ISSUE;
            core_run <= 1'b1;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        ISSUE: begin
          wd  <= '0;
          fsm <= EXEC;
        end
        EXEC: begin
          if (core_done) begin
            npc <= new_pc;
            fsm <= UPDATE;
          end else if (wd == WD_END) begin
            fsm    <= HALT;
            wd_err <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        UPDATE: begin
          pc          <= npc;
          instr_count <= instr_count + 1'b1;
          // breakpoint wins over step/run so a hit is never skipped
          if (bp_en && npc == bp_addr) begin
            fsm    <= HALT;
            wd_err <= 1'b0;
          end else if (mode_step || !run) begin
            fsm <= IDLE;
          end else begin
            fsm    <= FETCH;
            mem_rd <= 1'b1;
            lat    <= '0;
          end
        end
        HALT: begin
          if (clear) begin
            fsm    <= IDLE;
            wd_err <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_sequencer.sv
// tb_bitty_sequencer: directed checks of the bitty sequencer.
// Two instances cover MEM_LAT=1/TIMEOUT=8 and MEM_LAT=3.
module tb_bitty_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_a, run_b;
  logic       mode_step, step, clear, bp_en;
  logic [7:0] bp_addr;
  logic [7:0] new_pc_a, new_pc_b;
  logic       done_a = 1'b0;
  logic       done_b = 1'b0;

  logic [7:0]  pc_a, pc_b;
  logic        mem_rd_a, mem_rd_b;
  logic        core_run_a, core_run_b;
  logic        halted_a, halted_b;
  logic        wd_err_a, wd_err_b;
  logic [15:0] count_a, count_b;
  logic [2:0]  state_a, state_b;

  int checks = 0;
  int errors = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int delay_a = 1;
  int cr_cnt = 0;
  logic en_a = 1'b1;

  always #5 clk = ~clk;

  bitty_sequencer #(
    .AW(8), .CW(16), .MEM_LAT(1), .TIMEOUT(8), .RESET_PC(8'h00)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .run(run_a),
    .mode_step(mode_step), .step(step), .clear(clear),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .new_pc(new_pc_a), .core_done(done_a),
    .pc(pc_a), .mem_rd(mem_rd_a), .core_run(core_run_a),
    .halted(halted_a), .wd_err(wd_err_a),
    .instr_count(count_a), .state(state_a)
  );

  bitty_sequencer #(
    .AW(8), .CW(16), .MEM_LAT(3), .TIMEOUT(64), .RESET_PC(8'h00)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .run(run_b),
    .mode_step(mode_step), .step(step), .clear(clear),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .new_pc(new_pc_b), .core_done(done_b),
    .pc(pc_b), .mem_rd(mem_rd_b), .core_run(core_run_b),
    .halted(halted_b), .wd_err(wd_err_b),
    .instr_count(count_b), .state(state_b)
  );

  assign new_pc_a = pc_a + 8'd1;
  assign new_pc_b = pc_b + 8'd1;

  // core stand-ins: done in the delay-th EXEC cycle after core_run
  always @(posedge clk) begin
    if (core_run_a) begin
      cnt_a  <= delay_a - 1;
      done_a <= en_a && (delay_a == 1);
    end else if (cnt_a > 0) begin
      cnt_a  <= cnt_a - 1;
      done_a <= en_a && (cnt_a == 1);
    end else begin
      done_a <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (core_run_b) begin
      cnt_b  <= 4;
      done_b <= 1'b0;
    end else if (cnt_b > 0) begin
      cnt_b  <= cnt_b - 1;
      done_b <= (cnt_b == 1);
    end else begin
      done_b <= 1'b0;
    end
  end

  always @(posedge clk)
    if (core_run_a) cr_cnt <= cr_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halt(input int lim, input string tag);
    int n = 0;
    while (!halted_a && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(halted_a), 1);
  endtask

  initial begin
    int base;
    int n;
    int exec;
    rst_n = 1'b0;
    run_a = 1'b0;
    run_b = 1'b0;
    mode_step = 1'b0;
    step = 1'b0;
    clear = 1'b0;
    bp_en = 1'b0;
    bp_addr = 8'h00;
    tick(2);
    check("rst_pc", 32'(pc_a), 0);
    check("rst_state", 32'(state_a), 0);
    check("rst_mem_rd", 32'(mem_rd_a), 0);
    check("rst_core_run", 32'(core_run_a), 0);
    check("rst_halted", 32'(halted_a), 0);
    check("rst_wd_err", 32'(wd_err_a), 0);
    check("rst_count", 32'(count_a), 0);
    rst_n = 1'b1;
    tick(1);
    check("idle_no_run", 32'(state_a), 0);

    run_a = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      check("fr_mem_rd", 32'(mem_rd_a), 32'(i % 4 == 1));
      check("fr_core_run", 32'(core_run_a), 32'(i % 4 == 2));
      if (i % 4 == 1) check("fr_pc", 32'(pc_a), 32'((i - 1) / 4));
    end
    check("fr_count", 32'(count_a), 3);
    run_a = 1'b0;
    tick(4);
    check("stop_state", 32'(state_a), 0);
    check("stop_pc", 32'(pc_a), 4);
    check("stop_count", 32'(count_a), 4);

    run_b = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      check("lat_mem_rd", 32'(mem_rd_b), 32'(i % 10 == 1));
      check("lat_core_run", 32'(core_run_b), 32'(i % 10 == 4));
    end
    check("lat_count", 32'(count_b), 3);
    check("lat_pc", 32'(pc_b), 3);
    check("lat_state", 32'(state_b), 1);
    check("lat_halted", 32'(halted_b), 0);
    check("lat_wd_err", 32'(wd_err_b), 0);
    run_b = 1'b0;

    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("rst2_pc", 32'(pc_a), 0);
    bp_en = 1'b1;
    bp_addr = 8'h05;
    run_a = 1'b1;
    wait_halt(100, "bp_halt");
    check("bp_pc", 32'(pc_a), 5);
    check("bp_count", 32'(count_a), 5);
    check("bp_wd_err", 32'(wd_err_a), 0);
    check("bp_state", 32'(state_a), 5);
    tick(3);
    check("bp_hold_pc", 32'(pc_a), 5);

    mode_step = 1'b1;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_state", 32'(state_a), 0);
    check("clr_halted", 32'(halted_a), 0);
    base = cr_cnt;
    tick(5);
    check("step_wait_pc", 32'(pc_a), 5);
    check("step_wait_state", 32'(state_a), 0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(19);
    check("step1_state", 32'(state_a), 0);
    check("step1_pc", 32'(pc_a), 6);
    check("step1_count", 32'(count_a), 6);
    check("step1_halted", 32'(halted_a), 0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(19);
    check("step2_state", 32'(state_a), 0);
    check("step2_pc", 32'(pc_a), 7);
    check("step2_count", 32'(count_a), 7);
    check("step_pulses", 32'(cr_cnt - base), 2);

    mode_step = 1'b0;
    bp_en = 1'b0;
    en_a = 1'b0;
    run_a = 1'b1;
    n = 0;
    exec = 0;
    while (!halted_a && n < 40) begin
      @(negedge clk);
      n++;
      if (state_a == 3'd3) exec++;
    end
    check("wd_halted", 32'(halted_a), 1);
    check("wd_exec_cycles", 32'(exec), 8);
    check("wd_err", 32'(wd_err_a), 1);
    check("wd_pc", 32'(pc_a), 7);
    check("wd_count", 32'(count_a), 7);
    run_a = 1'b0;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("wd_clr_state", 32'(state_a), 0);
    check("wd_clr_err", 32'(wd_err_a), 0);
    check("wd_clr_halted", 32'(halted_a), 0);

    en_a = 1'b1;
    bp_en = 1'b1;
    bp_addr = 8'h2A;
    run_a = 1'b1;
    wait_halt(300, "bp2_halt");
    check("bp2_pc", 32'(pc_a), 32'h2A);
    check("bp2_count", 32'(count_a), 42);
    bp_en = 1'b0;
    delay_a = 6;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    n = 0;
    while (state_a != 3'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_in_exec", 32'(state_a), 3);
    check("ar_pc_before", 32'(pc_a), 32'h2A);
    #2 rst_n = 1'b0;
    #1;
    check("ar_pc", 32'(pc_a), 0);
    check("ar_state", 32'(state_a), 0);
    check("ar_mem_rd", 32'(mem_rd_a), 0);
    check("ar_core_run", 32'(core_run_a), 0);
    check("ar_halted", 32'(halted_a), 0);
    check("ar_wd_err", 32'(wd_err_a), 0);
    check("ar_count", 32'(count_a), 0);
    run_a = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(8);
    check("late_pc", 32'(pc_a), 0);
    check("late_state", 32'(state_a), 0);
    check("late_count", 32'(count_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitty_sequencer.md
Name: bitty_sequencer

Overview:
- Parametrised fetch/issue/retire controller for the bitty core; successor to the fixed 4-state run sequencer in the top level.
- Owns the PC and the fetch strobe to instruction memory, and pulses the core's run input once per instruction.
- Takes the next PC from the external branch logic on core_done.
- Adds configurable memory latency, single-step mode, a PC breakpoint, an execution watchdog and a retired-instruction counter.

Parameters:
AW, 8, PC / memory address width
CW, 16, retired-instruction counter width
MEM_LAT, 1, cycles from mem_rd to valid instruction on the memory output (>=1)
TIMEOUT, 64, max EXEC cycles without core_done before a watchdog halt (>=2)
RESET_PC, 0, PC value after reset (AW bits)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; enables sequencing
mode_step  in  1  1 = single-step mode
step  in  1  one-cycle pulse; starts one instruction in step mode
clear  in  1  one-cycle pulse; leaves HALT
bp_en  in  1  breakpoint enable
bp_addr  in  AW  breakpoint address
new_pc  in  AW  next PC from branch logic, valid while core_done=1
core_done  in  1  core finished current instruction
pc  out  AW  current fetch address
mem_rd  out  1  fetch strobe, one cycle per instruction
core_run  out  1  run pulse to core, one cycle per instruction
halted  out  1  in HALT state
wd_err  out  1  HALT was entered by watchdog
instr_count  out  CW  retired instructions, wraps at 2^CW
state  out  3  debug: IDLE=0 FETCH=1 ISSUE=2 EXEC=3 UPDATE=4 HALT=5

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, mem_rd=0, core_run=0, halted=0, wd_err=0, instr_count=0, latency and watchdog counters=0.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- IDLE: go to FETCH if run && (!mode_step || step). A step pulse outside IDLE is ignored. A step pulse with mode_step=0 has no extra effect.
- FETCH: mem_rd=1 on the first FETCH cycle only. Stay exactly MEM_LAT cycles, then go to ISSUE.
- ISSUE: core_run=1 for exactly this one cycle. Clear the watchdog counter. Go to EXEC.
- EXEC: wait for core_done; core_done=1 goes to UPDATE, capturing new_pc that cycle. Watchdog increments each EXEC cycle without core_done. On reaching TIMEOUT, go to HALT with wd_err=1 and pc unchanged.
- UPDATE: pc <= captured new_pc; instr_count += 1 (wraps). Next state, in priority order:
  - bp_en && captured new_pc==bp_addr -> HALT, wd_err=0.
  - mode_step || !run -> IDLE.
  - otherwise -> FETCH.
- HALT: halted=1; pc and instr_count hold. clear -> IDLE, with halted and wd_err cleared the next cycle. Resuming from a breakpoint executes the instruction at bp_addr. The breakpoint is checked again only on the following UPDATE.
- core_done outside EXEC is ignored and does not change pc.
- run deasserted mid-instruction: the instruction completes through UPDATE, then goes to IDLE. run is not sampled in FETCH, ISSUE or EXEC.
- Free-run cost per instruction: MEM_LAT + 1 (ISSUE) + N EXEC cycles + 1 (UPDATE), with N>=1 (N=1 when core_done arrives in the first EXEC cycle).
- pc wrap is handled entirely by new_pc; the sequencer does no PC arithmetic.
- Async reset mid-instruction: immediate return to reset values, with no pending mem_rd or core_run pulse.

Test Plan:
- Free run, MEM_LAT=1, core_done in the first EXEC cycle, new_pc=pc+1 -> mem_rd every 4 cycles, pc 0,1,2,3, instr_count=3 after 12 cycles post-start.
- MEM_LAT=3, core_done 5 cycles after core_run -> core_run exactly 3 cycles after mem_rd, 1 cycle wide, period 3+1+5+1=10 cycles.
- mode_step=1, run=1, two step pulses 20 cycles apart -> exactly 2 core_run pulses; state=IDLE between them; instr_count=2.
- bp_en=1, bp_addr=0x05, linear PCs from 0 -> halted=1 with pc=0x05, instr_count=5. Then clear -> the instruction at 0x05 executes, pc=0x06 with no halt.
- TIMEOUT=8, core_done never asserted -> HALT after 8 EXEC cycles, wd_err=1, pc unchanged. clear -> wd_err=0, state=IDLE.
- rst_n pulsed low during EXEC with pc=0x2A -> pc=RESET_PC and all outputs 0 asynchronously. A late core_done after reset -> ignored.
